// File: rtl/fog_demod_step_gen.sv
// fog_demod_step_gen
//   Closed-loop FOG front end feeding the phase ramp generator.
//   - Square-wave bias modulation o_mod (+/- i_mod_amp) with a one-clock o_trig
//     on the first clock of every half-period (tau).
//   - Demodulates the detector samples against the modulation polarity
//     (sum over the positive half minus sum over the negative half).
//   - Integrates the scaled error into the saturated ramp step o_step.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_adc        signed detector sample, one per clock
//   i_freq_cnt   half-period length N in clocks (values < 2 act as 2)
//   i_skip       samples blanked at the start of each half
//   i_mod_amp    signed modulation amplitude
//   i_gain_shift loop gain, error is arithmetically shifted right by this
//   i_fb_on      1 = integrate, 0 = hold step integrator at 0
//   o_mod        +amp in positive half, -amp in negative half
//   o_trig       one-clock pulse on the first clock of every half
//   o_step       signed saturated step integrator
//   o_err        last demodulated error (sum_pos - sum_neg)
//   o_err_vld    one-clock pulse when o_err updates in RUN
module fog_demod_step_gen #(
  parameter int ADC_BIT    = 14,
  parameter int OUTPUT_BIT = 16,
  parameter int CNT_BIT    = 16,
  parameter int ACC_BIT    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic signed [ADC_BIT-1:0]    i_adc,
  input  logic        [CNT_BIT-1:0]    i_freq_cnt,
  input  logic        [CNT_BIT-1:0]    i_skip,
  input  logic signed [OUTPUT_BIT-1:0] i_mod_amp,
  input  logic        [4:0]            i_gain_shift,
  input  logic                         i_fb_on,
  output logic signed [OUTPUT_BIT-1:0] o_mod,
  output logic                         o_trig,
  output logic signed [OUTPUT_BIT-1:0] o_step,
  output logic signed [ACC_BIT-1:0]    o_err,
  output logic                         o_err_vld
);

  typedef enum logic {ST_SETTLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic signed [OUTPUT_BIT-1:0] sat_step(input logic signed [ACC_BIT:0] v);
    logic signed [ACC_BIT:0] hi;
    logic signed [ACC_BIT:0] lo;
    hi = {{(ACC_BIT-OUTPUT_BIT+2){1'b0}}, {(OUTPUT_BIT-1){1'b1}}};
    lo = {{(ACC_BIT-OUTPUT_BIT+2){1'b1}}, {(OUTPUT_BIT-1){1'b0}}};
    if (v > hi)      sat_step = hi[OUTPUT_BIT-1:0];
    else if (v < lo) sat_step = lo[OUTPUT_BIT-1:0];
    else             sat_step = v[OUTPUT_BIT-1:0];
  endfunction

  state_t                      state_q, state_d;
  logic                        settle_q, settle_d;
  logic                        vld_d;

  // started_q distinguishes the idle reset cycle from the first real clock,
  // so the first clock after release shows cnt=0, positive, with o_trig.
  logic                        started_q;
  logic        [CNT_BIT-1:0]   cnt_q;
  logic        [CNT_BIT-1:0]   n_q;
  logic                        pol_q;
  logic signed [ACC_BIT-1:0]   half_sum_q;
  logic signed [ACC_BIT-1:0]   sum_pos_q;
  logic signed [ACC_BIT-1:0]   sum_neg_q;

  logic signed [OUTPUT_BIT-1:0] mod_p1;
  logic                         trig_p1;
  logic signed [ACC_BIT-1:0]    err_p1;
  logic                         err_vld_p1;
  logic signed [OUTPUT_BIT-1:0] step_acc_p2;

  logic        [CNT_BIT-1:0]   n_in;
  logic                        last;
  logic                        take;
  logic                        neg_end;
  logic                        n_change;
  logic signed [ACC_BIT-1:0]   adc_ext;
  logic signed [ACC_BIT-1:0]   half_tot;
  logic signed [ACC_BIT-1:0]   err_new;
  logic signed [ACC_BIT-1:0]   err_shift;
  logic signed [ACC_BIT:0]     step_sum;

  assign n_in     = (i_freq_cnt < CNT_BIT'(2)) ? CNT_BIT'(2) : i_freq_cnt;
  assign last     = started_q && (cnt_q == n_q - CNT_BIT'(1));
  assign take     = started_q && (cnt_q >= i_skip);
  assign neg_end  = last && !pol_q;
  assign n_change = neg_end && (n_in != n_q);
  assign adc_ext  = {{(ACC_BIT-ADC_BIT){i_adc[ADC_BIT-1]}}, i_adc};
  // Completed half includes the sample taken on its own last clock.
  assign half_tot = half_sum_q + (take ? adc_ext : '0);
  assign err_new  = sum_pos_q - half_tot;

  // Stage p1 -> p2: scaled error added to the step integrator
  assign err_shift = err_p1 >>> i_gain_shift;
  assign step_sum  = {{(ACC_BIT-OUTPUT_BIT+1){step_acc_p2[OUTPUT_BIT-1]}}, step_acc_p2}
                   + {err_shift[ACC_BIT-1], err_shift};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Only period ends (negative half finishing) move the FSM. A changed N
  // restarts settling; otherwise two clean periods are needed to reach RUN.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vld_d    = 1'b0;
    if (neg_end) begin
      if (n_change) begin
        state_d  = ST_SETTLE;
        settle_d = 1'b0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_q) begin
              state_d  = ST_RUN;
              settle_d = 1'b0;
            end else begin
              settle_d = 1'b1;
            end
          end
          ST_RUN:  vld_d = 1'b1;
          default: state_d = ST_SETTLE;
        endcase
      end
    end
  end

  // Stage p0 -> p1: counter, half sums, registered modulation and error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      started_q  <= 1'b0;
      cnt_q      <= '0;
      n_q        <= '0;
      pol_q      <= 1'b1;
      half_sum_q <= '0;
      sum_pos_q  <= '0;
      sum_neg_q  <= '0;
      mod_p1     <= '0;
      trig_p1    <= 1'b0;
      err_p1     <= '0;
      err_vld_p1 <= 1'b0;
    end else begin
      err_vld_p1 <= vld_d;
      if (!started_q) begin
        started_q  <= 1'b1;
        cnt_q      <= '0;
        pol_q      <= 1'b1;
        n_q        <= n_in;
        half_sum_q <= '0;
        trig_p1    <= 1'b1;
        mod_p1     <= i_mod_amp;
      end else if (last) begin
        cnt_q      <= '0;
        pol_q      <= ~pol_q;
        half_sum_q <= '0;
        trig_p1    <= 1'b1;
        mod_p1     <= pol_q ? -i_mod_amp : i_mod_amp;
        if (pol_q) begin
          sum_pos_q <= half_tot;
        end else begin
          sum_neg_q <= half_tot;
          err_p1    <= err_new;
          n_q       <= n_in;
        end
      end else begin
        cnt_q      <= cnt_q + CNT_BIT'(1);
        half_sum_q <= half_tot;
        trig_p1    <= 1'b0;
        mod_p1     <= pol_q ? i_mod_amp : -i_mod_amp;
      end
    end
  end

  // Stage p2: integrator; feedback-off clear takes priority over an update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_acc_p2 <= '0;
    end else if (!i_fb_on) begin
      step_acc_p2 <= '0;
    end else if (err_vld_p1) begin
      step_acc_p2 <= sat_step(step_sum);
    end
  end

  assign o_mod     = mod_p1;
  assign o_trig    = trig_p1;
  assign o_err     = err_p1;
  assign o_err_vld = err_vld_p1;
  assign o_step    = step_acc_p2;

endmodule
